// File: rtl/sparse_operand_sequencer.sv
// sparse_operand_sequencer: streams NON_ZERO_WEIGHTS compressed (activation, weight) pairs into the PE and captures its result
//
// Optional build macro: SEQ_RELU_EN (fused ReLU on the captured result).
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-low reset
//   i_start             one-cycle request, sampled only in IDLE
//   i_act_base          activation window base address, latched on start
//   i_wgt_base          first weight-entry address, latched on start
//   o_busy              high from the cycle after an accepted start until done
//   o_done              one-cycle pulse together with o_result_valid
//   o_w_rd_en/addr      weight-memory read port, i_w_rd_data = {offset, weight} one cycle later
//   o_a_rd_en/addr      activation-memory read port, i_a_rd_data one cycle later
//   o_pe_activation     activation to the PE (0 when o_pe_valid is low)
//   o_pe_weight         weight to the PE (0 when o_pe_valid is low)
//   o_pe_valid          the pair on o_pe_* is a real term
//   i_pe_out            PE accumulated result
//   o_result            captured result, held until the next capture
//   o_result_valid      one-cycle pulse when o_result updates
module sparse_operand_sequencer #(
    parameter int NON_ZERO_WEIGHTS = 27,
    parameter int BIT_SIZE         = 16,
    parameter int OFFSET_BITS      = 8,
    parameter int ADDR_BITS        = 16,
    parameter int PE_LATENCY       = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_start,
    input  logic [ADDR_BITS-1:0]            i_act_base,
    input  logic [ADDR_BITS-1:0]            i_wgt_base,
    output logic                            o_busy,
    output logic                            o_done,
    output logic                            o_w_rd_en,
    output logic [ADDR_BITS-1:0]            o_w_rd_addr,
    input  logic [BIT_SIZE+OFFSET_BITS-1:0] i_w_rd_data,
    output logic                            o_a_rd_en,
    output logic [ADDR_BITS-1:0]            o_a_rd_addr,
    input  logic [BIT_SIZE-1:0]             i_a_rd_data,
    output logic [BIT_SIZE-1:0]             o_pe_activation,
    output logic [BIT_SIZE-1:0]             o_pe_weight,
    output logic                            o_pe_valid,
    input  logic [BIT_SIZE-1:0]             i_pe_out,
    output logic [BIT_SIZE-1:0]             o_result,
    output logic                            o_result_valid
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_WAIT  = 2'd3;
    localparam int CW = $clog2(NON_ZERO_WEIGHTS + PE_LATENCY + 3);

    logic [1:0]             r_state;
    logic [CW-1:0]          r_cnt;
    logic [ADDR_BITS-1:0]   r_act_base;
    logic                   r_w_rd_en;
    logic [ADDR_BITS-1:0]   r_w_rd_addr;
    logic                   r_wv;
    logic                   r_av;
    logic [BIT_SIZE-1:0]    r_wgt;
    logic                   r_pe_valid;
    logic [BIT_SIZE-1:0]    r_pe_act;
    logic [BIT_SIZE-1:0]    r_pe_wgt;
    logic [BIT_SIZE-1:0]    r_result;
    logic                   r_done;
    logic [OFFSET_BITS-1:0] w_offset;
    logic [BIT_SIZE-1:0]    w_capture;

    assign w_offset = i_w_rd_data[BIT_SIZE+OFFSET_BITS-1:BIT_SIZE];

`ifdef SEQ_RELU_EN
    assign w_capture = i_pe_out[BIT_SIZE-1] ? '0 : i_pe_out;
`else
    assign w_capture = i_pe_out;
`endif

    // r_wv marks the cycle a weight entry is on i_w_rd_data, so the gather read is issued straight from it
    assign o_a_rd_en       = r_wv;
    assign o_a_rd_addr     = r_wv ? r_act_base + ADDR_BITS'(w_offset) : '0;
    assign o_busy          = r_state != S_IDLE;
    assign o_done          = r_done;
    assign o_result_valid  = r_done;
    assign o_result        = r_result;
    assign o_w_rd_en       = r_w_rd_en;
    assign o_w_rd_addr     = r_w_rd_addr;
    assign o_pe_activation = r_pe_act;
    assign o_pe_weight     = r_pe_wgt;
    assign o_pe_valid      = r_pe_valid;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_act_base  <= '0;
            r_w_rd_en   <= 1'b0;
            r_w_rd_addr <= '0;
            r_wv        <= 1'b0;
            r_av        <= 1'b0;
            r_wgt       <= '0;
            r_pe_valid  <= 1'b0;
            r_pe_act    <= '0;
            r_pe_wgt    <= '0;
            r_result    <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_wv       <= r_w_rd_en;
            r_av       <= r_wv;
            r_wgt      <= r_wv ? i_w_rd_data[BIT_SIZE-1:0] : '0;
            // weight is delayed one stage so it meets its gathered activation on the PE inputs
            r_pe_valid <= r_av;
            r_pe_act   <= r_av ? i_a_rd_data : '0;
            r_pe_wgt   <= r_av ? r_wgt : '0;
            case (r_state)
                S_IDLE: begin
                    // a start coinciding with the done pulse is dropped
                    if (i_start && !r_done) begin
                        r_state     <= S_ISSUE;
                        r_act_base  <= i_act_base;
                        r_w_rd_addr <= i_wgt_base;
                        r_w_rd_en   <= 1'b1;
                        r_cnt       <= '0;
                    end
                end
                S_ISSUE: begin
                    if (r_cnt == CW'(NON_ZERO_WEIGHTS - 1)) begin
                        r_state     <= S_DRAIN;
                        r_w_rd_en   <= 1'b0;
                        r_w_rd_addr <= '0;
                        r_cnt       <= '0;
                    end else begin
                        r_cnt       <= r_cnt + CW'(1);
                        r_w_rd_addr <= r_w_rd_addr + ADDR_BITS'(1);
                    end
                end
                S_DRAIN: begin
                    r_state <= (r_cnt == CW'(2)) ? S_WAIT : S_DRAIN;
                    r_cnt   <= (r_cnt == CW'(2)) ? '0 : r_cnt + CW'(1);
                end
                default: begin
                    if (r_cnt == CW'(PE_LATENCY - 1)) begin
                        r_state  <= S_IDLE;
                        r_cnt    <= '0;
                        r_result <= w_capture;
                        r_done   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sparse_operand_sequencer.sv
// tb_sparse_operand_sequencer: scoreboard bench for sparse_operand_sequencer with memory and PE models
module tb_sparse_operand_sequencer;
    typedef struct {
        int          cyc;
        logic [31:0] val;
        logic [31:0] mask;
    } exp_t;

    localparam logic [31:0] M_ALL  = 32'hFFFF_FFFF;
    localparam logic [31:0] M_CTRL = 32'hFE00_0000;
    localparam logic [31:0] M_BUSY = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] act_base = '0;
    logic [15:0] wgt_base = '0;
    logic        busy, done, w_rd_en, a_rd_en, pe_valid, result_valid;
    logic [15:0] w_rd_addr, a_rd_addr, pe_activation, pe_weight, pe_out, result;
    logic [23:0] w_rd_data = '0;
    logic [15:0] a_rd_data = '0;

    logic [23:0] wmem [0:65535];
    logic [15:0] amem [0:65535];

    logic        clr = 1'b0;
    logic        ovr = 1'b0;
    logic [15:0] ovr_val = '0;
    logic [15:0] acc = '0, d1 = '0, d2 = '0, d3 = '0;
    logic signed [31:0] prod;
    logic        finish_req = 1'b0;
    logic [31:0] snap;

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    exp_t qw[$], qa[$], qp[$], qr[$], qs[$];

    sparse_operand_sequencer dut (
        .clk(clk), .rst(rst), .i_start(start), .i_act_base(act_base), .i_wgt_base(wgt_base),
        .o_busy(busy), .o_done(done), .o_w_rd_en(w_rd_en), .o_w_rd_addr(w_rd_addr),
        .i_w_rd_data(w_rd_data), .o_a_rd_en(a_rd_en), .o_a_rd_addr(a_rd_addr),
        .i_a_rd_data(a_rd_data), .o_pe_activation(pe_activation), .o_pe_weight(pe_weight),
        .o_pe_valid(pe_valid), .i_pe_out(pe_out), .o_result(result), .o_result_valid(result_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (w_rd_en) w_rd_data <= wmem[w_rd_addr];
        if (a_rd_en) a_rd_data <= amem[a_rd_addr];
    end

    // PE model: Q8.8 multiply-accumulate, result appears PE_LATENCY cycles after the last sampled pair
    always_comb prod = $signed(pe_activation) * $signed(pe_weight);
    always @(posedge clk) begin
        acc <= clr ? 16'h0 : acc + prod[23:8];
        d1  <= acc;
        d2  <= d1;
        d3  <= d2;
    end
    assign pe_out = ovr ? ovr_val : d3;

    assign snap = {busy, done, result_valid, w_rd_en, a_rd_en, pe_valid,
                   |{w_rd_addr, a_rd_addr, pe_activation, pe_weight}, 9'h0, result};

    task automatic cmp(input string nm, input exp_t e, input logic [31:0] act);
        n_chk++;
        if (e.cyc != cyc || (act & e.mask) != e.val) begin
            n_fail++;
            $display("FAIL %s: got %h at cycle %0d, expected %h at cycle %0d", nm, act & e.mask, cyc, e.val, e.cyc);
        end
    endtask

    task automatic unexp(input string nm, input logic [31:0] act);
        n_chk++;
        n_fail++;
        $display("FAIL %s: unexpected output %h at cycle %0d", nm, act, cyc);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (w_rd_en) begin
            if (qw.size() == 0) unexp("w_rd_addr", {16'h0, w_rd_addr});
            else begin e = qw.pop_front(); cmp("w_rd_addr", e, {16'h0, w_rd_addr}); end
        end
        if (a_rd_en) begin
            if (qa.size() == 0) unexp("a_rd_addr", {16'h0, a_rd_addr});
            else begin e = qa.pop_front(); cmp("a_rd_addr", e, {16'h0, a_rd_addr}); end
        end
        if (pe_valid) begin
            if (qp.size() == 0) unexp("pe_pair", {pe_activation, pe_weight});
            else begin e = qp.pop_front(); cmp("pe_pair", e, {pe_activation, pe_weight}); end
        end else begin
            n_chk++;
            if ({pe_activation, pe_weight} != 32'h0) begin
                n_fail++;
                $display("FAIL pe_idle_zero: got %h at cycle %0d, expected 00000000", {pe_activation, pe_weight}, cyc);
            end
        end
        if (done) begin
            if (qr.size() == 0) unexp("done_result", {14'h0, result_valid, busy, result});
            else begin e = qr.pop_front(); cmp("done_result", e, {14'h0, result_valid, busy, result}); end
        end
        while (qs.size() > 0 && qs[0].cyc <= cyc) begin
            e = qs.pop_front();
            cmp("snapshot", e, snap);
        end
        if (finish_req) begin
            n_chk++;
            if (qw.size() + qa.size() + qp.size() + qr.size() + qs.size() != 0) begin
                n_fail++;
                $display("FAIL drained: pending w=%0d a=%0d pe=%0d res=%0d snap=%0d, expected all 0",
                         qw.size(), qa.size(), qp.size(), qr.size(), qs.size());
            end
            $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
            $finish;
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic launch(input logic [15:0] ab, input logic [15:0] wb, input logic [15:0] res);
        int c;
        logic [15:0] wa, aa;
        logic [23:0] ent;
        c = cyc;
        start = 1'b1;
        act_base = ab;
        wgt_base = wb;
        clr = 1'b1;
        for (int k = 0; k < 27; k++) begin
            wa  = wb + 16'(k);
            ent = wmem[wa];
            aa  = ab + {8'h0, ent[23:16]};
            qw.push_back('{cyc: c + 1 + k, val: {16'h0, wa}, mask: M_ALL});
            qa.push_back('{cyc: c + 2 + k, val: {16'h0, aa}, mask: M_ALL});
            qp.push_back('{cyc: c + 4 + k, val: {amem[aa], ent[15:0]}, mask: M_ALL});
        end
        qr.push_back('{cyc: c + 35, val: {14'h0, 1'b1, 1'b0, res}, mask: M_ALL});
        qs.push_back('{cyc: c + 1, val: M_BUSY, mask: M_BUSY});
        step();
        start = 1'b0;
        clr = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 60; i++) begin
            step();
            if (done) break;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c;
        for (int i = 0; i < 65536; i++) begin
            wmem[i] = '0;
            amem[i] = 16'(i) ^ 16'h3C3C;
        end
        for (int k = 0; k < 27; k++) begin
            wmem[16'h0100 + k] = {8'(k), 16'h0100};
            amem[16'h2000 + k] = 16'h0100;
            wmem[16'h0200 + k] = {(k == 0) ? 8'd0 : 8'(4 * k + 1), 16'h0100};
            amem[16'hFFF0 + ((k == 0) ? 16'd0 : 16'(4 * k + 1))] = 16'h0010 + 16'(k);
        end
        for (int i = 1; i <= 3; i++) qs.push_back('{cyc: i, val: 32'h0, mask: M_ALL});
        repeat (3) step();
        rst = 1'b1;
        c = cyc;
        for (int i = 1; i <= 20; i++) qs.push_back('{cyc: c + i, val: 32'h0, mask: M_CTRL});
        repeat (20) step();

        launch(16'h2000, 16'h0100, 16'h1B00);
        wait_done();
        step();

        c = cyc;
        launch(16'hFFF0, 16'h0200, 16'h030F);
        repeat (9) step();
        start = 1'b1;
        act_base = 16'h1234;
        wgt_base = 16'h0100;
        step();
        start = 1'b0;
        wait_done();
        start = 1'b1;
        act_base = 16'h2000;
        wgt_base = 16'h0100;
        step();
        launch(16'h2000, 16'h0100, 16'h1B00);
        wait_done();
        step();

        c = cyc;
        launch(16'h2000, 16'h0100, 16'h1B00);
        repeat (14) step();
        rst = 1'b0;
        qs.push_back('{cyc: c + 16, val: 32'h0, mask: M_ALL});
        step();
        step();
        rst = 1'b1;
        qw.delete();
        qa.delete();
        qp.delete();
        qr.delete();
        repeat (5) step();
        launch(16'hFFF0, 16'h0200, 16'h030F);
        wait_done();
        step();

        ovr = 1'b1;
        ovr_val = 16'hFF00;
`ifdef SEQ_RELU_EN
        launch(16'h2000, 16'h0100, 16'h0000);
`else
        launch(16'h2000, 16'h0100, 16'hFF00);
`endif
        wait_done();
        step();
        ovr_val = 16'h0280;
        launch(16'h2000, 16'h0100, 16'h0280);
        wait_done();
        step();
        ovr = 1'b0;

        repeat (3) step();
        finish_req = 1'b1;
    end
endmodule
